alu_rs: RTL

//  Reservation station feeding the single integer ALU in the Tomasulo core. Holds dispatched
//  ALU/branch/jump ops until both operands are resolved, snoops the ALU and LSB CDB broadcasts
//  to wake operands, and issues at most one ready op per cycle to the ALU with a new_calculate pulse.

---
 rtl/alu_rs.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Purpose  : Reservation station in front of the single integer ALU of the
//            Tomasulo core. It holds dispatched ALU/branch/jump ops until both
//            operands are resolved and snoops the ALU and LSB CDB broadcasts to
//            wake operands. Each cycle it issues at most one ready op to the
//            ALU, marked by a one-cycle new_calculate strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: RS_CDB_BYPASS_EN
//   defined   : an operand woken by a CDB in the current cycle already counts
//               as ready for select. The CDB value is muxed into alu_vj/alu_vk,
//               so the wake-to-strobe latency is one cycle.
//   undefined : select looks only at registered ready bits, giving a
//               wake-to-strobe latency of two cycles.
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   rdy                  global ready; 0 freezes all state
//   clear                mispredict flush (synchronous, highest priority)
//   disp_*               dispatch request: op, inst, pc, imm, operand
//                        tags/values and the destination ROB tag
//   alu_cdb_*, lsb_cdb_* result broadcasts snooped for operand wakeup
//   rs_full              every entry busy
//   new_calculate        one-cycle issue strobe to the ALU
//   alu_*                issued op fields; they hold while new_calculate=0
// ============================================================================
module alu_rs #(
    parameter int RS_SIZE   = 16,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 clear,
    input  logic                 disp_valid,
    input  logic [5:0]           disp_op,
    input  logic [31:0]          disp_inst,
    input  logic [31:0]          disp_pc,
    input  logic [31:0]          disp_imm,
    input  logic                 disp_qj_busy,
    input  logic [TAG_WIDTH-1:0] disp_qj,
    input  logic [31:0]          disp_vj,
    input  logic                 disp_qk_busy,
    input  logic [TAG_WIDTH-1:0] disp_qk,
    input  logic [31:0]          disp_vk,
    input  logic [TAG_WIDTH-1:0] disp_dest,
    input  logic                 alu_cdb_valid,
    input  logic [TAG_WIDTH-1:0] alu_cdb_tag,
    input  logic [31:0]          alu_cdb_value,
    input  logic                 lsb_cdb_valid,
    input  logic [TAG_WIDTH-1:0] lsb_cdb_tag,
    input  logic [31:0]          lsb_cdb_value,
    output logic                 rs_full,
    output logic                 new_calculate,
    output logic [5:0]           alu_op,
    output logic [31:0]          alu_inst,
    output logic [31:0]          alu_vj,
    output logic [31:0]          alu_vk,
    output logic [31:0]          alu_pc,
    output logic [31:0]          alu_imm,
    output logic [TAG_WIDTH-1:0] alu_entry
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    // Entry storage
    logic [RS_SIZE-1:0]   valid_q;
    logic [RS_SIZE-1:0]   qj_busy_q;
    logic [RS_SIZE-1:0]   qk_busy_q;
    logic [5:0]           op_q   [RS_SIZE];
    logic [31:0]          inst_q [RS_SIZE];
    logic [31:0]          pc_q   [RS_SIZE];
    logic [31:0]          imm_q  [RS_SIZE];
    logic [31:0]          vj_q   [RS_SIZE];
    logic [31:0]          vk_q   [RS_SIZE];
    logic [TAG_WIDTH-1:0] qj_q   [RS_SIZE];
    logic [TAG_WIDTH-1:0] qk_q   [RS_SIZE];
    logic [TAG_WIDTH-1:0] dest_q [RS_SIZE];

    // Operand state after this cycle's CDB snoop
    logic [RS_SIZE-1:0]   qj_busy_d;
    logic [RS_SIZE-1:0]   qk_busy_d;
    logic [31:0]          vj_d [RS_SIZE];
    logic [31:0]          vk_d [RS_SIZE];

    // Incoming dispatch operands after same-cycle forwarding
    logic                 disp_qj_busy_d;
    logic                 disp_qk_busy_d;
    logic [31:0]          disp_vj_d;
    logic [31:0]          disp_vk_d;

    logic [RS_SIZE-1:0]   ready;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_hit;
    logic [IDX_W-1:0]     free_idx;
    logic                 free_hit;

    // Returns {still_busy, value}. The ALU CDB is checked first; tags on the
    // two buses never collide, so the order only matters for determinism.
    function automatic logic [32:0] snoop(input logic                 busy,
                                          input logic [TAG_WIDTH-1:0] tag,
                                          input logic [31:0]          val);
        if (busy && alu_cdb_valid && (alu_cdb_tag == tag))
            return {1'b0, alu_cdb_value};
        else if (busy && lsb_cdb_valid && (lsb_cdb_tag == tag))
            return {1'b0, lsb_cdb_value};
        return {busy, val};
    endfunction

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            {qj_busy_d[i], vj_d[i]} = snoop(qj_busy_q[i], qj_q[i], vj_q[i]);
            {qk_busy_d[i], vk_d[i]} = snoop(qk_busy_q[i], qk_q[i], vk_q[i]);
        end
        {disp_qj_busy_d, disp_vj_d} = snoop(disp_qj_busy, disp_qj, disp_vj);
        {disp_qk_busy_d, disp_vk_d} = snoop(disp_qk_busy, disp_qk, disp_vk);
    end

`ifdef RS_CDB_BYPASS_EN
    assign ready = valid_q & ~qj_busy_d & ~qk_busy_d;
`else
    assign ready = valid_q & ~qj_busy_q & ~qk_busy_q;
`endif

    // Lowest-index priority encoders. Scanning downward lets the lowest
    // matching index be the last one written. An entry that issues this
    // cycle is still valid, so it never shows up as free.
    always_comb begin
        sel_idx  = '0;
        sel_hit  = 1'b0;
        free_idx = '0;
        free_hit = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_idx = IDX_W'(i);
                sel_hit = 1'b1;
            end
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
                free_hit = 1'b1;
            end
        end
    end

    assign rs_full = &valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            qj_busy_q     <= '0;
            qk_busy_q     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]   <= '0;
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                imm_q[i]  <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
            end
            new_calculate <= 1'b0;
            alu_op        <= '0;
            alu_inst      <= '0;
            alu_vj        <= '0;
            alu_vk        <= '0;
            alu_pc        <= '0;
            alu_imm       <= '0;
            alu_entry     <= '0;
        end else if (clear) begin
            valid_q       <= '0;
            new_calculate <= 1'b0;
        end else if (rdy) begin
            // Wakeup. Updating free entries as well is harmless because
            // their contents are rewritten on dispatch.
            qj_busy_q <= qj_busy_d;
            qk_busy_q <= qk_busy_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                vj_q[i] <= vj_d[i];
                vk_q[i] <= vk_d[i];
            end

            new_calculate <= sel_hit;
            if (sel_hit) begin
                valid_q[sel_idx] <= 1'b0;
                alu_op           <= op_q[sel_idx];
                alu_inst         <= inst_q[sel_idx];
                alu_pc           <= pc_q[sel_idx];
                alu_imm          <= imm_q[sel_idx];
                alu_entry        <= dest_q[sel_idx];
                // vj_d/vk_d equal the stored value unless a bypass wake
                // happened this cycle.
                alu_vj           <= vj_d[sel_idx];
                alu_vk           <= vk_d[sel_idx];
            end

            // The free slot can never equal sel_idx, so these writes do not
            // collide with the wakeup or issue updates above.
            if (disp_valid && free_hit) begin
                valid_q[free_idx]   <= 1'b1;
                op_q[free_idx]      <= disp_op;
                inst_q[free_idx]    <= disp_inst;
                pc_q[free_idx]      <= disp_pc;
                imm_q[free_idx]     <= disp_imm;
                dest_q[free_idx]    <= disp_dest;
                qj_q[free_idx]      <= disp_qj;
                qk_q[free_idx]      <= disp_qk;
                qj_busy_q[free_idx] <= disp_qj_busy_d;
                qk_busy_q[free_idx] <= disp_qk_busy_d;
                vj_q[free_idx]      <= disp_vj_d;
                vk_q[free_idx]      <= disp_vk_d;
            end
        end else begin
            new_calculate <= 1'b0;
        end
    end

endmodule
`default_nettype wire
